// File: rtl/dual_port_memory.sv
// -----------------------------------------------------------------------------
// dual_port_memory
//   True dual-port synchronous RAM, 2**ADDR_WIDTH x DATA_WIDTH (default
//   4096 x 32). It is the shared data memory of the datapath. Ports A and B
//   share one clock and one storage array. Each port has a registered read
//   output, so read latency is one cycle.
//
//   Read/write rules:
//     - Same-port read-during-write is write-first: q_x returns data_x.
//     - Cross-port read-during-write returns the old contents. The new word
//       is visible from the next edge.
//     - If both ports write one address in the same edge, port A's data is
//       stored. Both q_a and q_b return data_a.
//     - Every array word powers up to 0. Reset clears only the output
//       registers and blocks writes while it is held.
//
//   Optional build macro: DPMEM_COLLISION_DETECT_EN
//     When it is defined, coll is a registered flag. It pulses for one cycle
//     after an edge where both ports write the same address. Simulation
//     builds also print a warning with that address. When it is undefined,
//     coll is tied to 0.
//
// Ports:
//   clk            single clock, rising-edge active
//   rst_n          asynchronous active-low reset (clears q_a, q_b, coll)
//   data_a/data_b  write data, DATA_WIDTH
//   addr_a/addr_b  word address, ADDR_WIDTH
//   we_a/we_b      write enable, active high
//   q_a/q_b        registered read data, DATA_WIDTH
//   coll           write-collision flag (0 unless the macro is defined)
// -----------------------------------------------------------------------------
module dual_port_memory #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] data_a,
  input  logic [DATA_WIDTH-1:0] data_b,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic                  we_a,
  input  logic                  we_b,
  output logic [DATA_WIDTH-1:0] q_a,
  output logic [DATA_WIDTH-1:0] q_b,
  output logic                  coll
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  // The declaration initialiser gives the zeroed power-up contents.
  logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};

  logic                  wr_coll_p0;
  logic [DATA_WIDTH-1:0] rd_a_p0;
  logic [DATA_WIDTH-1:0] rd_b_p0;
  logic [DATA_WIDTH-1:0] q_a_p1;
  logic [DATA_WIDTH-1:0] q_b_p1;

  // ---- stage p0: resolve the read value of each port for this edge ----
  assign wr_coll_p0 = we_a && we_b && (addr_a == addr_b);

  always_comb begin
    rd_a_p0 = mem[addr_a];
    if (we_a) begin
      rd_a_p0 = data_a;
    end
  end

  // On a write collision port B reports the word that is actually stored,
  // and that word is port A's data.
  always_comb begin
    rd_b_p0 = mem[addr_b];
    if (we_b) begin
      rd_b_p0 = wr_coll_p0 ? data_a : data_b;
    end
  end

  // Writes are suppressed while reset is held. The array itself is never
  // cleared by reset. Port B's write is skipped on a collision so that
  // port A's data wins.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (we_b && !wr_coll_p0) begin
        mem[addr_b] <= data_b;
      end
      if (we_a) begin
        mem[addr_a] <= data_a;
      end
    end
  end

  // ---- stage p1: registered read outputs ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_a_p1 <= '0;
      q_b_p1 <= '0;
    end else begin
      q_a_p1 <= rd_a_p0;
      q_b_p1 <= rd_b_p0;
    end
  end

  assign q_a = q_a_p1;
  assign q_b = q_b_p1;

`ifdef DPMEM_COLLISION_DETECT_EN
  logic coll_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coll_p1 <= 1'b0;
    end else begin
      coll_p1 <= wr_coll_p0;
    end
  end

  assign coll = coll_p1;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rst_n && wr_coll_p0) begin
      $warning("dual_port_memory: write collision at address 0x%0h", addr_a);
    end
  end
`endif
`else
  assign coll = 1'b0;
`endif

endmodule

// File: tb/tb_dual_port_memory.sv
module tb_dual_port_memory;

  localparam int DW    = 32;
  localparam int AW    = 12;
  localparam int DEPTH = 2 ** AW;

  logic          clk    = 1'b0;
  logic          rst_n  = 1'b1;
  logic [DW-1:0] data_a = '0;
  logic [DW-1:0] data_b = '0;
  logic [AW-1:0] addr_a = '0;
  logic [AW-1:0] addr_b = '0;
  logic          we_a   = 1'b0;
  logic          we_b   = 1'b0;
  logic [DW-1:0] q_a;
  logic [DW-1:0] q_b;
  logic          coll;

  dual_port_memory #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .data_a(data_a),
    .data_b(data_b),
    .addr_a(addr_a),
    .addr_b(addr_b),
    .we_a  (we_a),
    .we_b  (we_b),
    .q_a   (q_a),
    .q_b   (q_b),
    .coll  (coll)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          c;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] model [DEPTH];
  int            vectors     = 0;
  int            miscompares = 0;
  logic          stim_vld    = 1'b0;
  logic          vld_p1;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference behaviour: each port reads the array as it was before the edge.
  // A writing port sees its own data. On a same-address double write the
  // stored word is A's data, and both ports report it.
  task automatic apply(input logic wa, input logic [AW-1:0] aa, input logic [DW-1:0] da,
                       input logic wb, input logic [AW-1:0] ab, input logic [DW-1:0] db);
    exp_t e;
    logic clash;
    clash = wa && wb && (aa == ab);
    e.a = wa ? da : model[aa];
    e.b = wb ? (clash ? da : db) : model[ab];
`ifdef DPMEM_COLLISION_DETECT_EN
    e.c = clash;
`else
    e.c = 1'b0;
`endif
    if (wb) model[ab] = db;
    if (wa) model[aa] = da;
    sb.push_back(e);
    we_a = wa; addr_a = aa; data_a = da;
    we_b = wb; addr_b = ab; data_b = db;
    stim_vld = 1'b1;
  endtask

  task automatic drive(input logic wa, input logic [AW-1:0] aa, input logic [DW-1:0] da,
                       input logic wb, input logic [AW-1:0] ab, input logic [DW-1:0] db);
    @(negedge clk);
    apply(wa, aa, da, wb, ab, db);
  endtask

  task automatic idle();
    @(negedge clk);
    stim_vld = 1'b0;
    we_a = 1'b0;
    we_b = 1'b0;
  endtask

  function automatic logic [AW-1:0] rand_addr();
    int r;
    r = $urandom_range(0, 15);
    return (r < 8) ? AW'(r) : AW'(DEPTH - 16 + r);
  endfunction

  // Monitor: an operation that was issued before an edge is checked on the
  // following falling edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_p1 <= 1'b0;
    else        vld_p1 <= stim_vld;
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (vld_p1) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL sb_underflow: output seen with no expectation queued at %0t", $time);
        end else begin
          e = sb.pop_front();
          check("q_a", q_a, e.a);
          check("q_b", q_b, e.b);
          check("coll", {31'b0, coll}, {31'b0, e.c});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, vectors=%0d", vectors);
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) model[i] = '0;

    // Reset at start-up.
    #1 rst_n = 1'b0;
    #1;
    check("rst_init_q_a", q_a, '0);
    check("rst_init_q_b", q_b, '0);
    check("rst_init_coll", {31'b0, coll}, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Power-up contents are zero.
    drive(0, 12'd100, 0, 0, 12'd2000, 0);

    // Dual write, then swapped read.
    drive(1, 12'd0, 32'd1234, 1, 12'd1, 32'd720);
    drive(0, 12'd1, 0, 0, 12'd0, 0);

    // Write-first on port A. Port B reads the old word at the same address.
    drive(1, 12'd5, 32'hDEADBEEF, 0, 12'd5, 0);

    // Cross-port old data.
    drive(1, 12'd7, 32'd11, 0, 12'd0, 0);
    drive(1, 12'd7, 32'd99, 0, 12'd7, 0);
    drive(0, 12'd7, 0, 0, 12'd7, 0);

    // Write collision. Port A wins.
    drive(1, 12'd3, 32'hAAAA, 1, 12'd3, 32'hBBBB);
    drive(0, 12'd3, 0, 0, 12'd3, 0);

    // Top address, written by B and read by A. Address 0 is untouched.
    drive(0, 12'd0, 0, 1, 12'd4095, 32'h12345678);
    drive(0, 12'd4095, 0, 0, 12'd0, 0);

    // Leave nonzero values on both outputs, then reset mid-cycle.
    drive(0, 12'd4095, 0, 0, 12'd7, 0);
    idle();
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_q_a", q_a, '0);
    check("rst_async_q_b", q_b, '0);
    check("rst_async_coll", {31'b0, coll}, '0);

    // Writes attempted while reset is held must be ignored.
    we_a = 1'b1; addr_a = 12'd7;    data_a = 32'h0BAD0BAD;
    we_b = 1'b1; addr_b = 12'd4095; data_b = 32'h0BAD0BAD;
    repeat (3) @(negedge clk);
    check("rst_hold_q_a", q_a, '0);
    check("rst_hold_q_b", q_b, '0);

    // The first edge after release performs a normal access.
    rst_n = 1'b1;
    apply(0, 12'd7, 0, 0, 12'd4095, 0);
    drive(1, 12'd4095, 32'h55AA55AA, 0, 12'd7, 0);
    drive(0, 12'd4095, 0, 0, 12'd4095, 0);

    // Randomised traffic over a small address pool at both ends of the
    // range, so that collisions and read-during-write cases occur often.
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 1)), rand_addr(), $urandom(),
            1'($urandom_range(0, 1)), rand_addr(), $urandom());
    end

    idle();
    repeat (3) @(negedge clk);
    check("sb_drain", DW'(sb.size()), '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
